bru_predict: RTL

- Parametrised branch resolution unit for the pipelined core; successor to the single-cycle combinational branch unit.
- Resolves RISC-V conditional branches and jumps (XLEN-wide compare) with a one-cycle registered result.
- Holds a BHT_ENTRIES-deep table of 2-bit saturating counters: fetch-stage prediction lookup, resolve-stage training.
- Flags mispredictions and keeps saturating branch and mispredict statistics counters.

---
 rtl/bru_predict.sv | 71 +++++++
 1 files changed

// File: rtl/bru_predict.sv
// bru_predict: one-cycle branch resolution with a 2-bit saturating-counter BHT and saturating statistics.
module bru_predict #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter int         CNT_W       = 16,
  parameter logic [1:0] INIT_STATE  = 2'b01
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  PredPC,
  output logic             PredTaken,
  input  logic             ResValid,
  input  logic [XLEN-1:0]  ResPC,
  input  logic [XLEN-1:0]  Aru,
  input  logic [XLEN-1:0]  Bru,
  input  logic [4:0]       BrOp,
  input  logic             PredWasTaken,
  input  logic             ClrStats,
  output logic             OutValid,
  output logic             NextPCSrc,
  output logic             Mispredict,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0]       r_bht [BHT_ENTRIES];
  logic             r_valid, r_npc, r_mis;
  logic [CNT_W-1:0] r_bcnt, r_mcnt;
  logic [IW-1:0]    w_pidx, w_ridx;
  logic             w_eq, w_lt, w_ltu, w_cmp, w_cond, w_legal, w_taken, w_train;
  logic [1:0]       w_cur, w_next;
  assign w_pidx       = PredPC[IW+1:2];
  assign w_ridx       = ResPC[IW+1:2];
  assign PredTaken    = r_bht[w_pidx][1];
  assign OutValid     = r_valid;
  assign NextPCSrc    = r_npc;
  assign Mispredict   = r_mis;
  assign BranchCount  = r_bcnt;
  assign MispredCount = r_mcnt;
  always_comb begin
    w_eq    = Aru == Bru;
    w_lt    = $signed(Aru) < $signed(Bru);
    w_ltu   = Aru < Bru;
    w_cmp   = BrOp[2] ? (BrOp[1] ? w_ltu : w_lt) : w_eq;
    w_cond  = !BrOp[4] && BrOp[3];
    // funct3 010/011 have no branch meaning
    w_legal = w_cond && !(!BrOp[2] && BrOp[1]);
    w_taken = BrOp[4] || (w_legal && (w_cmp ^ BrOp[0]));
    w_train = ResValid && w_legal;
    w_cur   = r_bht[w_ridx];
    w_next  = w_taken ? ((w_cur == 2'b11) ? w_cur : w_cur + 2'd1)
                      : ((w_cur == 2'b00) ? w_cur : w_cur - 2'd1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= INIT_STATE;
      r_valid <= 1'b0;
      r_npc   <= 1'b0;
      r_mis   <= 1'b0;
      r_bcnt  <= '0;
      r_mcnt  <= '0;
    end else begin
      r_valid <= ResValid;
      r_npc   <= ResValid && w_taken;
      r_mis   <= ResValid && (w_taken != PredWasTaken);
      if (w_train) r_bht[w_ridx] <= w_next;
      r_bcnt  <= ClrStats ? '0 : r_bcnt + CNT_W'(w_train && !(&r_bcnt));
      r_mcnt  <= ClrStats ? '0 : r_mcnt + CNT_W'(r_mis && !(&r_mcnt));
    end
  end
endmodule
